shift_piso: RTL and testbench
=============================

# shift_piso

Parametrised parallel-in/serial-out shift register with a frame sequencer, generalising the fixed 7-bit shifter used in the digital-fundamentals examples. A `start` strobe loads a `WIDTH`-bit word, which is shifted out one bit per clock in a selectable bit order. The block reports `busy` and a one-cycle `done` per frame, and accepts a new word on the last bit so frames can stream without gaps. It sits between any parallel data source and a serial line driver such as an LED, a UART-style bit stream or a test pin.

## Interface
- `WIDTH`, default 7: word length in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts out bit `WIDTH-1` first; 0 shifts out bit 0 first.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  load request; sampled on the rising edge.
- `datain`  in  WIDTH  parallel word; captured on the edge where `start` is accepted.
- `rotate`  in  1  recirculate request. Present only with `SHIFT_ROTATE_EN`.
- `dataout`  out  1  serial bit, registered.
- `busy`  out  1  high while a frame is being shifted out.
- `done`  out  1  one-cycle pulse marking the end of each frame.

## Operation
- State machine with two states:
  - IDLE: `busy`=0, `dataout`=0.
  - SHIFT: `busy`=1.
- Internal state:
  - Shift register `sreg` (WIDTH bits).
  - Bit counter `cnt`, width `$clog2(WIDTH+1)`.
  - Saved word `hold`, present only with `SHIFT_ROTATE_EN`.
- IDLE, `start`=1: load `datain`, drive its first bit on `dataout`, set `cnt`=1, go to SHIFT.
- IDLE, `start`=0: no change.
- SHIFT, `cnt` < WIDTH: drive the next bit on `dataout` and increment `cnt`.
  - The shift direction follows `MSB_FIRST`.
  - The vacated bit is filled with 0.
- SHIFT, `cnt` = WIDTH (last bit already on the line): pulse `done`=1 for this edge only, then:
  - `start`=1: load `datain`, drive its first bit, set `cnt`=1, stay in SHIFT (seamless streaming).
  - `start`=0: go to IDLE; `dataout`=0, `busy`=0.
- `start` is ignored while in SHIFT with `cnt` < WIDTH. A frame is never truncated or corrupted by `start`.
- `datain` is don't-care except on the accepting edge.
- Reset at any time forces IDLE:
  - `sreg`=0, `cnt`=0, `dataout`=0, `busy`=0, `done`=0.
  - A partial frame is discarded and `done` is not issued for it.

## Timing
- The accepting edge is T0.
- The first bit is valid on `dataout` from T0 to T1. Bit k (k = 0..WIDTH-1) is valid from Tk to Tk+1.
- `busy` rises at T0 and falls at T(WIDTH) if no new start arrives.
- `done` is high from T(WIDTH) to T(WIDTH)+1. It overlaps the first bit of the next frame when frames are streaming.
- Latency from `start` to the first bit is 1 clock.
- Frame period is WIDTH clocks when streaming. In non-streaming operation, the minimum period is WIDTH+1 clocks.
- `dataout`, `busy` and `done` are glitch-free registered outputs.
- Deasserting reset takes effect asynchronously. The first `start` can be accepted on the first rising edge after `rst` goes high.

## Configuration
- `SHIFT_ROTATE_EN` defined:
  - Adds the `rotate` input and the `hold` register. `hold` is loaded with `datain` on every accepted start.
  - At the final-bit edge, with `start`=0 and `rotate`=1, `sreg` is reloaded from `hold` and the same word is shifted again.
    - The block stays in SHIFT and `done` still pulses once per frame.
  - `start`=1 takes priority over `rotate`.
  - Deasserting `rotate` ends the frame normally at its last bit.
- Not defined: the `rotate` port and `hold` register do not exist, and behaviour is identical to `rotate`=0.

## Test plan
- Reset: hold `rst`=0 for 50 ns mid-frame, with `clk` period 40 ns. Required: `dataout`=0, `busy`=0, `done`=0 immediately and asynchronously; no `done` for the aborted frame.
- Basic frame: WIDTH=7, MSB_FIRST=1, `datain`=7'b1110101, single `start` pulse.
  - `dataout` = 1,1,1,0,1,0,1 on T0..T6.
  - `busy` high for 7 cycles; `done` high only at T7; then IDLE.
- Bit order: MSB_FIRST=0, same word. `dataout` = 1,0,1,0,1,1,1.
- Streaming: hold `start`=1 with `datain`=7'h55, then 7'h2A at the final-bit edge. Required: 14 contiguous bits (1010101 then 0101010), `busy` never drops, `done` pulses at T7 and T14.
- Ignored start: pulse `start` with `datain`=7'h00 at T3 of a 7'h7F frame. Required: the frame outputs seven 1s unchanged and `done` fires once at T7.
- Rotate, with `SHIFT_ROTATE_EN`: 7'b1110101 with `rotate`=1 for 3 frames, then 0.
  - Pattern repeats 3 times.
  - `done` pulses at T7, T14 and T21.
  - `busy` falls at T21.

Source files
------------

// File: rtl/shift_piso.sv
// Parallel-in/serial-out shift register with a frame sequencer and seamless streaming.
// Optional feature macro: SHIFT_ROTATE_EN (adds the rotate input and the hold register).
module shift_piso #(
    parameter int WIDTH     = 7,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] datain,
`ifdef SHIFT_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             dataout,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             dout_d;
    logic             done_d;
    logic             load;
    logic [WIDTH-1:0] src;
`ifdef SHIFT_ROTATE_EN
    logic [WIDTH-1:0] hold, hold_d;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Drop the bit that just went onto the line; the vacated end fills with 0.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        cnt_d   = cnt;
        dout_d  = dataout;
        done_d  = 1'b0;
        load    = 1'b0;
        src     = datain;
`ifdef SHIFT_ROTATE_EN
        hold_d  = hold;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != LAST) begin
                    dout_d = first_bit(sreg);
                    sreg_d = advance(sreg);
                    cnt_d  = cnt + 1'b1;
                end else begin
                    // Last bit is already on the line: close the frame.
                    done_d = 1'b1;
                    if (start) begin
                        load = 1'b1;
`ifdef SHIFT_ROTATE_EN
                    end else if (rotate) begin
                        load = 1'b1;
                        src  = hold;
`endif
                    end else begin
                        state_d = IDLE;
                        dout_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            state_d = SHIFT;
            dout_d  = first_bit(src);
            sreg_d  = advance(src);
            cnt_d   = CW'(1);
`ifdef SHIFT_ROTATE_EN
            if (src == datain && start) begin
                hold_d = datain;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            dataout <= 1'b0;
            done    <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            hold    <= '0;
`endif
        end else begin
            state   <= state_d;
            sreg    <= sreg_d;
            cnt     <= cnt_d;
            dataout <= dout_d;
            done    <= done_d;
`ifdef SHIFT_ROTATE_EN
            hold    <= hold_d;
`endif
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shift_piso.sv
// Bench for shift_piso: MSB-first and LSB-first instances driven together, checked per cycle.
module tb_shift_piso;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] datain = '0;
`ifdef SHIFT_ROTATE_EN
    logic         rotate = 1'b0;
`endif
    logic dout_m, busy_m, done_m;
    logic dout_l, busy_l, done_l;

    int checks = 0;
    int failures = 0;

    // Reference frame model: which word is on the line and which bit index is showing.
    bit           m_act = 1'b0;
    int           m_pos = 0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_hold = '0;
    bit           m_done = 1'b0;

    always #20 clk = ~clk;

    shift_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .start(start), .datain(datain),
`ifdef SHIFT_ROTATE_EN
        .rotate(rotate),
`endif
        .dataout(dout_m), .busy(busy_m), .done(done_m)
    );

    shift_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .start(start), .datain(datain),
`ifdef SHIFT_ROTATE_EN
        .rotate(rotate),
`endif
        .dataout(dout_l), .busy(busy_l), .done(done_l)
    );

    function automatic logic [5:0] got_v();
        return {dout_m, dout_l, busy_m, busy_l, done_m, done_l};
    endfunction

    function automatic logic [5:0] exp_v();
        logic bm, bl;
        bm = m_act ? m_word[W-1-m_pos] : 1'b0;
        bl = m_act ? m_word[m_pos]     : 1'b0;
        return {bm, bl, m_act, m_act, m_done, m_done};
    endfunction

    task automatic model_edge(input logic s, input logic [W-1:0] d, input logic r);
        m_done = 1'b0;
        if (!m_act) begin
            if (s) begin
                m_word = d; m_hold = d; m_pos = 0; m_act = 1'b1;
            end
        end else if (m_pos < W-1) begin
            m_pos++;
        end else begin
            m_done = 1'b1;
            if (s) begin
                m_word = d; m_hold = d; m_pos = 0;
`ifdef SHIFT_ROTATE_EN
            end else if (r) begin
                m_word = m_hold; m_pos = 0;
`endif
            end else begin
                m_act = 1'b0;
            end
        end
`ifndef SHIFT_ROTATE_EN
        if (r) m_done = m_done;
`endif
    endtask

    task automatic step(input logic s, input logic [W-1:0] d, input logic r);
        start  = s;
        datain = d;
`ifdef SHIFT_ROTATE_EN
        rotate = r;
`endif
        @(posedge clk);
        model_edge(s, d, r);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] w;
        checks++;
        if (got_v() !== 6'b0) begin
            failures++; $display("FAIL reset_initial got=%b exp=%b", got_v(), 6'b0);
        end
        #9 rst = 1'b1;
        w = W'($urandom);
        step(1'b1, w | W'(1), 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, W'($urandom), 1'b0);
        #10 rst = 1'b0;
        #1;
        checks++;
        if (got_v() !== 6'b0) begin
            failures++; $display("FAIL reset_async got=%b exp=%b", got_v(), 6'b0);
        end
        #48;
        checks++;
        if (got_v() !== 6'b0) begin
            failures++; $display("FAIL reset_held got=%b exp=%b", got_v(), 6'b0);
        end
        #1 rst = 1'b1;
        m_act = 1'b0; m_done = 1'b0; m_pos = 0; m_word = '0; m_hold = '0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, W'($urandom), 1'b0);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++; $display("FAIL reset_after cyc=%0d got=%b exp=%b", k, got_v(), exp_v());
            end
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] word;
        logic [W-1:0] seq_m;
        logic [W-1:0] seq_l;
        logic [5:0]   lit;
        word  = 7'b1110101;
        seq_m = 7'b1110101;   // MSB-first line order read from bit 6 down
        seq_l = 7'b1110101;   // LSB-first line order read from bit 0 up
        for (int k = 0; k <= 8; k++) begin
            step(k == 0, word, 1'b0);
            if (k < 7) lit = {seq_m[6-k], seq_l[k], 2'b11, 2'b00};
            else if (k == 7) lit = 6'b000011;
            else lit = 6'b000000;
            checks++;
            if (got_v() !== lit) begin
                failures++; $display("FAIL basic_frame T%0d got=%b exp=%b", k, got_v(), lit);
            end
            checks++;
            if (got_v() !== exp_v()) begin
                failures++; $display("FAIL basic_model T%0d got=%b exp=%b", k, got_v(), exp_v());
            end
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k <= 15; k++) begin
            if (k == 0) step(1'b1, 7'h55, 1'b0);
            else if (k <= 7) step(1'b1, 7'h2A, 1'b0);
            else step(1'b0, 7'h00, 1'b0);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++; $display("FAIL stream T%0d got=%b exp=%b", k, got_v(), exp_v());
            end
        end
    endtask

    task automatic test_ignored_start();
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) step(1'b1, 7'h7F, 1'b0);
            else step(k == 3, 7'h00, 1'b0);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++; $display("FAIL ignored_start T%0d got=%b exp=%b", k, got_v(), exp_v());
            end
        end
    endtask

`ifdef SHIFT_ROTATE_EN
    task automatic test_rotate();
        for (int k = 0; k <= 22; k++) begin
            step(k == 0, 7'b1110101, k < 20);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++; $display("FAIL rotate T%0d got=%b exp=%b", k, got_v(), exp_v());
            end
        end
    endtask
`endif

    task automatic test_random();
        logic s, r;
        for (int k = 0; k < 400; k++) begin
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) == 0);
            step(s, W'($urandom), r);
            checks++;
            if (got_v() !== exp_v()) begin
                failures++; $display("FAIL random cyc=%0d got=%b exp=%b", k, got_v(), exp_v());
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_stream();
        test_ignored_start();
`ifdef SHIFT_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
